// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the modified MIPS pipeline: datapath widths,
// the fetch FSM encoding and the default reset vector.
package mips_pipe_pkg;
    localparam int          XLEN             = 32;
    localparam int          INSTR_BYTES      = 4;
    localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'd100;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;
endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register: load a new instruction, hold, flush to a zeroed
// bubble, or just drop the valid bit. Cleared asynchronously.
module ifid_reg
    import mips_pipe_pkg::*;
(
    input  logic            clk,
    input  logic            reset_n,
    input  logic            load,
    input  logic            flush,
    input  logic            kill,
    input  logic [XLEN-1:0] instr_in,
    input  logic [XLEN-1:0] pc4_in,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc4,
    output logic            valid
);
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc4_q, pc4_d;
    logic            valid_q, valid_d;

    // flush beats load beats kill; with none asserted the register holds
    always_comb begin
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (flush) begin
            instr_d = NOP_WORD;
            pc4_d   = '0;
            valid_d = 1'b0;
        end else if (load) begin
            instr_d = instr_in;
            pc4_d   = pc4_in;
            valid_d = 1'b1;
        end else if (kill) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instr_q <= NOP_WORD;
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign instr = instr_q;
    assign pc4   = pc4_q;
    assign valid = valid_q;
endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC and the RUN/HALT fetch FSM, counts retired fetches,
// and feeds the IF/ID register from the combinational instruction memory.
module fetch_stage
    import mips_pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = DEFAULT_RESET_PC,
    parameter int          HALT_ON_ZERO = 1,
    parameter int          CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             stall,
    input  logic             br_taken,
    input  logic [XLEN-1:0]  br_target,
    input  logic [XLEN-1:0]  imem_instr,
    output logic [XLEN-1:0]  imem_pc,
    output logic [XLEN-1:0]  ifid_instr,
    output logic [XLEN-1:0]  ifid_pc4,
    output logic             ifid_valid,
    output logic             halted,
    output logic [CNT_W-1:0] fetch_count
);
    fetch_state_t     state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             halted_q, halted_d;
    logic             ld, fl, kl;
    logic [XLEN-1:0]  pc_plus4;

    assign pc_plus4 = pc_q + XLEN'(INSTR_BYTES);

    // Priority: branch redirect > halted > stall > zero-word halt > fetch.
    // A branch is honoured even in HALT since it comes from an older instruction.
    always_comb begin
        pc_d    = pc_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        ld      = 1'b0;
        fl      = 1'b0;
        kl      = 1'b0;
        if (br_taken) begin
            pc_d    = {br_target[XLEN-1:2], 2'b00};
            fl      = 1'b1;
            state_d = RUN;
        end else if (state_q == HALT) begin
            kl = 1'b1;
        end else if (stall) begin
            pc_d = pc_q;
        end else if ((HALT_ON_ZERO != 0) && (imem_instr == NOP_WORD)) begin
            kl      = 1'b1;
            state_d = HALT;
        end else begin
            pc_d = pc_plus4;
            ld   = 1'b1;
            if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
        end
        halted_d = (state_d == HALT);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= RUN;
            pc_q     <= RESET_PC;
            cnt_q    <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
            halted_q <= halted_d;
        end
    end

    ifid_reg u_ifid (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (ld),
        .flush    (fl),
        .kill     (kl),
        .instr_in (imem_instr),
        .pc4_in   (pc_plus4),
        .instr    (ifid_instr),
        .pc4      (ifid_pc4),
        .valid    (ifid_valid)
    );

    assign imem_pc     = pc_q;
    assign halted      = halted_q;
    assign fetch_count = cnt_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: two instances (halt-on-zero with 16-bit counter, and
// no-halt with a 3-bit counter) compared every cycle against a reference model.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        reset_n, stall, br_taken;
    logic [31:0] br_target;
    logic [31:0] imem0, imem1, pc0, pc1, ins0, ins1, p40, p41;
    logic        v0, v1, h0, h1;
    logic [15:0] cnt0;
    logic [2:0]  cnt1;

    logic [31:0] wmem [0:255];
    int          n_chk = 0;
    int          n_err = 0;

    // reference model state, one slot per instance
    logic [31:0] m_pc [2];
    logic [31:0] m_ins[2];
    logic [31:0] m_p4 [2];
    bit          m_v  [2];
    bit          m_h  [2];
    int unsigned m_cnt[2];
    int unsigned cmax [2] = '{65535, 7};
    bit          hz   [2] = '{1'b1, 1'b0};

    always #5 clk = ~clk;

    assign imem0 = wmem[pc0[9:2]];
    assign imem1 = wmem[pc1[9:2]];

    fetch_stage #(.RESET_PC(32'd100), .HALT_ON_ZERO(1), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .stall(stall), .br_taken(br_taken),
        .br_target(br_target), .imem_instr(imem0), .imem_pc(pc0),
        .ifid_instr(ins0), .ifid_pc4(p40), .ifid_valid(v0), .halted(h0),
        .fetch_count(cnt0));

    fetch_stage #(.RESET_PC(32'd100), .HALT_ON_ZERO(0), .CNT_W(3)) dut_s (
        .clk(clk), .reset_n(reset_n), .stall(stall), .br_taken(br_taken),
        .br_target(br_target), .imem_instr(imem1), .imem_pc(pc1),
        .ifid_instr(ins1), .ifid_pc4(p41), .ifid_valid(v1), .halted(h1),
        .fetch_count(cnt1));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pc[i] = 32'd100; m_ins[i] = 0; m_p4[i] = 0;
            m_v[i] = 0; m_h[i] = 0; m_cnt[i] = 0;
        end
    endtask

    task automatic model_edge();
        logic [31:0] w;
        for (int i = 0; i < 2; i++) begin
            w = wmem[m_pc[i][9:2]];
            if (br_taken) begin
                m_pc[i] = br_target & 32'hFFFF_FFFC;
                m_ins[i] = 0; m_p4[i] = 0; m_v[i] = 0; m_h[i] = 0;
            end else if (m_h[i]) begin
                m_v[i] = 0;
            end else if (!stall) begin
                if (hz[i] && w == 32'h0) begin
                    m_v[i] = 0; m_h[i] = 1;
                end else begin
                    m_ins[i] = w; m_p4[i] = m_pc[i] + 4; m_v[i] = 1;
                    m_pc[i] = m_pc[i] + 4;
                    if (m_cnt[i] < cmax[i]) m_cnt[i]++;
                end
            end
        end
    endtask

    task automatic check_all();
        check("pc0",    pc0,            m_pc[0]);
        check("instr0", ins0,           m_ins[0]);
        check("pc4_0",  p40,            m_p4[0]);
        check("valid0", {31'b0, v0},    {31'b0, m_v[0]});
        check("halt0",  {31'b0, h0},    {31'b0, m_h[0]});
        check("cnt0",   {16'b0, cnt0},  m_cnt[0]);
        check("pc1",    pc1,            m_pc[1]);
        check("instr1", ins1,           m_ins[1]);
        check("pc4_1",  p41,            m_p4[1]);
        check("valid1", {31'b0, v1},    {31'b0, m_v[1]});
        check("halt1",  {31'b0, h1},    {31'b0, m_h[1]});
        check("cnt1",   {29'b0, cnt1},  m_cnt[1]);
    endtask

    // inputs are set at the falling edge before calling; results sampled 1 after the rise
    task automatic step();
        @(posedge clk);
        if (reset_n) model_edge();
        #1;
        check_all();
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0; stall = 1'b0; br_taken = 1'b0; br_target = 32'h0;
        for (int i = 0; i < 256; i++)
            wmem[i] = (($urandom % 16) == 0) ? 32'h0 : ($urandom | 32'h1);
        for (int k = 0; k < 8; k++) wmem[25 + k] = 32'h4808_0000 + k * 32'h0001_0004;
        wmem[33]  = 32'h0;
        wmem[50]  = 32'h2413_0005;
        for (int k = 51; k < 55; k++) wmem[k] = $urandom | 32'h1;
        wmem[175] = 32'h2413_000F;
        wmem[176] = 32'h0;
        wmem[255] = 32'h1234_5679;
        model_reset();

        @(negedge clk);
        check_all();
        check("rst_pc", pc0, 32'd100);
        reset_n = 1'b1;

        step();
        check("first_instr", ins0, 32'h4808_0000);
        check("first_pc4", p40, 32'd104);
        check("first_pc", pc0, 32'd104);
        step();
        stall = 1'b1;
        repeat (3) step();
        check("stall_pc", pc0, 32'd108);
        check("stall_instr", ins0, 32'h4809_0004);
        stall = 1'b0;
        step();
        check("release_instr", ins0, 32'h480A_0008);
        check("release_pc", pc0, 32'd112);
        repeat (5) step();
        check("eighth_instr", ins0, 32'h480F_001C);
        check("eighth_cnt", {16'b0, cnt0}, 32'd8);
        step();
        check("halt_flag", {31'b0, h0}, 32'd1);
        check("halt_pc", pc0, 32'd132);
        for (int i = 0; i < 10; i++) begin
            stall = $urandom_range(0, 1);
            step();
        end
        check("halt_hold", {31'b0, h0}, 32'd1);
        check("halt_cnt", {16'b0, cnt0}, 32'd8);

        stall = 1'b0; br_taken = 1'b1; br_target = 32'd203;
        step();
        br_taken = 1'b0;
        check("unhalt_pc", pc0, 32'd200);
        check("unhalt_flag", {31'b0, h0}, 32'd0);
        step();
        check("target_instr", ins0, 32'h2413_0005);
        repeat (3) step();

        #2 reset_n = 1'b0;
        #1 model_reset();
        check_all();
        check("async_pc", pc0, 32'd100);
        @(negedge clk);
        step();
        reset_n = 1'b1;
        step();
        br_taken = 1'b1; stall = 1'b1; br_target = 32'd701;
        step();
        br_taken = 1'b0; stall = 1'b0;
        check("brst_pc", pc0, 32'd700);
        check("brst_valid", {31'b0, v0}, 32'd0);
        step();
        check("brst_instr", ins0, 32'h2413_000F);
        check("brst_pc4", p40, 32'd704);

        br_taken = 1'b1; br_target = 32'hFFFF_FFFF;
        step();
        br_taken = 1'b0;
        step();
        check("wrap_pc", pc0, 32'h0);

        for (int i = 0; i < 800; i++) begin
            stall    = ($urandom % 10) < 3;
            br_taken = ($urandom % 10) == 0;
            br_target = (($urandom % 10) == 0) ? $urandom : $urandom_range(0, 1023);
            step();
        end
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
